lane_phase_sequencer: RTL and testbench
=======================================

// Module: lane_phase_sequencer
// PURPOSE
//  Traffic-phase FSM feeding the enabler stage: cycles 4 approach lanes through
//  GREEN -> YELLOW -> ALL_RED, requests each lane's green duration from the optimizer,
//  and drives lane_sel (into enabler_2bit) plus dur_en (gates enabler_12bit/32bit).
//  Sits between the duration optimizer and the enablers/lamp drivers.
// PARAMETERS
//  YELLOW_T   3    yellow duration, in ticks
//  ALLRED_T   2    all-red clearance, in ticks
//  MIN_GREEN  5    lower clamp on requested green, in ticks
//  MAX_GREEN  120  upper clamp on requested green, in ticks (<= 4095)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  run         in   1   level; 0 = hold current state/count (freeze), 1 = advance
//  tick        in   1   1-cycle timebase strobe (1 s)
//  green_time  in   12  optimizer green duration for lane_sel, in ticks
//  green_valid in   1   green_time valid; consumed only while req is high
//  req         out  1   request for green_time of lane_sel
//  dur_en      out  1   enable to enabler_12bit; 1 for exactly the accept cycle
//  lane_sel    out  2   active lane index 0..3
//  light       out  2   00 RED/ALL_RED, 01 GREEN, 10 YELLOW, 11 IDLE
//  count       out  12  ticks remaining in current phase
//  phase_done  out  1   1-cycle pulse when ALL_RED ends (lane advances)
// BEHAVIOUR
//  - Reset: state IDLE, lane_sel=0, light=11, count=0, req=0, dur_en=0, phase_done=0.
//    rst has priority over every input, including mid-phase; all lamps go to IDLE at once.
//  - IDLE: when run=1, go to REQ on the next clk.
//  - REQ: req=1 (registered). On green_valid&&run, latch clamp(green_time) into count,
//    pulse dur_en, drop req, and enter GREEN on the next clk. A tick in REQ is ignored.
//  - Clamp: v<MIN_GREEN -> MIN_GREEN (covers 0); v>MAX_GREEN -> MAX_GREEN; else v.
//  - GREEN/YELLOW/ALL_RED: on tick&&run, if count==1 load the next phase's time
//    (GREEN->YELLOW_T, YELLOW->ALLRED_T); otherwise count-1.
//  - A phase therefore lasts exactly N ticks.
//  - ALL_RED end: lane_sel <= lane_sel+1 (3 wraps to 0), pulse phase_done, go to REQ.
//  - run=0: no state, count or lane change; req holds its value; green_valid is ignored.
//  - count never underflows. count==0 outside IDLE/REQ is unreachable; if detected,
//    force ALL_RED with ALLRED_T.
//  - Simultaneous tick+green_valid in REQ: accept green_valid, drop the tick.
//  - Outputs are registered; latency green_valid -> light=01 is 1 clk.
// STRUCTURE
//  - Shared package (traffic_pkg): state enum {IDLE,REQ,GREEN,YELLOW,ALL_RED};
//    light encodings L_RED/L_GREEN/L_YELLOW/L_IDLE; lane width 2; duration width 12.
//  - One sub-module: phase_timer (12-bit loadable down-counter with tick/run gating,
//    exposes count and a last==1 flag). The FSM and clamp stay in the top module.
// TESTING
//  1 rst, run=1, green_valid=1 with green_time=10 -> req 1 clk after IDLE;
//    dur_en pulses once; GREEN 10 ticks, YELLOW 3, ALL_RED 2; phase_done; lane_sel=1.
//  2 green_time=0 -> GREEN 5 ticks; green_time=12'hFFF -> GREEN 120 ticks.
//  3 Run 4 full cycles -> lane_sel 0,1,2,3,0 (wrap); phase_done pulses 4 times.
//  4 In GREEN with count=7, hold run=0 for 5 ticks -> count stays 7; resume gives 7 more ticks.
//  5 Assert rst in YELLOW with count=2 -> next clk light=11, lane_sel=0, count=0, req=0.
//  6 In REQ, tick and green_valid in the same cycle (green_time=8) -> GREEN with count=8;
//    the tick is not counted.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types and widths for the lane phase sequencer and its timer.
package traffic_pkg;

  localparam int unsigned LANE_W = 2;
  localparam int unsigned DUR_W  = 12;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    GREEN   = 3'd2,
    YELLOW  = 3'd3,
    ALL_RED = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    L_RED    = 2'b00,
    L_GREEN  = 2'b01,
    L_YELLOW = 2'b10,
    L_IDLE   = 2'b11
  } light_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for the timed phases; decrements on tick while running.
module phase_timer
  import traffic_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             en,
  input  logic             tick,
  input  logic             run,
  output logic [DUR_W-1:0] count,
  output logic             last_c
);

  // Load has priority; the count saturates at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && tick && run && (count != '0)) begin
      count <= count - DUR_W'(1);
    end
  end

  assign last_c = (count == DUR_W'(1));

endmodule

// File: rtl/lane_phase_sequencer.sv
// Four-lane GREEN -> YELLOW -> ALL_RED sequencer with optimizer handshake.
module lane_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              tick,
  input  logic [DUR_W-1:0]  green_time,
  input  logic              green_valid,
  output logic              req,
  output logic              dur_en,
  output logic [LANE_W-1:0] lane_sel,
  output logic [1:0]        light,
  output logic [DUR_W-1:0]  count,
  output logic              phase_done
);

  state_t           state;
  light_t           light_q;
  logic             accept;
  logic             adv;
  logic             timed;
  logic             zero;
  logic             last_c;
  logic             tmr_load;
  logic [DUR_W-1:0] tmr_val;
  logic             tmr_en;

  function automatic logic [DUR_W-1:0] clamp_green(input logic [DUR_W-1:0] v);
    if (v < DUR_W'(MIN_GREEN)) begin
      return DUR_W'(MIN_GREEN);
    end else if (v > DUR_W'(MAX_GREEN)) begin
      return DUR_W'(MAX_GREEN);
    end
    return v;
  endfunction

  assign accept = (state == REQ) && green_valid && run;
  assign adv    = tick && run;
  assign timed  = (state == GREEN) || (state == YELLOW) || (state == ALL_RED);
  assign zero   = (count == '0);
  assign light  = light_q;

  // Timer control: load on accept, phase change or zero recovery; otherwise count down.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    if (accept) begin
      tmr_load = 1'b1;
      tmr_val  = clamp_green(green_time);
    end else if (timed) begin
      if (zero) begin
        tmr_load = 1'b1;
        tmr_val  = DUR_W'(ALLRED_T);
      end else if (last_c) begin
        tmr_load = adv;
        case (state)
          GREEN:   tmr_val = DUR_W'(YELLOW_T);
          YELLOW:  tmr_val = DUR_W'(ALLRED_T);
          default: tmr_val = '0;
        endcase
      end else begin
        tmr_en = 1'b1;
      end
    end
  end

  phase_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .tick     (tick),
    .run      (run),
    .count    (count),
    .last_c   (last_c)
  );

  // Phase FSM with registered handshake, lamp and lane outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      light_q    <= L_IDLE;
      lane_sel   <= '0;
      req        <= 1'b0;
      dur_en     <= 1'b0;
      phase_done <= 1'b0;
    end else begin
      dur_en     <= 1'b0;
      phase_done <= 1'b0;
      case (state)
        IDLE: begin
          if (run) begin
            state   <= REQ;
            req     <= 1'b1;
            light_q <= L_RED;
          end
        end
        REQ: begin
          if (accept) begin
            state   <= GREEN;
            req     <= 1'b0;
            dur_en  <= 1'b1;
            light_q <= L_GREEN;
          end
        end
        GREEN, YELLOW, ALL_RED: begin
          if (zero) begin
            state   <= ALL_RED;
            light_q <= L_RED;
          end else if (adv && last_c) begin
            case (state)
              GREEN: begin
                state   <= YELLOW;
                light_q <= L_YELLOW;
              end
              YELLOW: begin
                state   <= ALL_RED;
                light_q <= L_RED;
              end
              default: begin
                state      <= REQ;
                req        <= 1'b1;
                light_q    <= L_RED;
                lane_sel   <= LANE_W'(lane_sel + 1'b1);
                phase_done <= 1'b1;
              end
            endcase
          end
        end
        default: begin
          state   <= IDLE;
          light_q <= L_IDLE;
          req     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_phase_sequencer.sv
// Directed and randomized checks of lane_phase_sequencer against a phase-table model.
module tb_lane_phase_sequencer;

  localparam int YT   = 3;
  localparam int AT   = 2;
  localparam int MING = 5;
  localparam int MAXG = 120;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        tick;
  logic [11:0] green_time;
  logic        green_valid;
  logic        req;
  logic        dur_en;
  logic [1:0]  lane_sel;
  logic [1:0]  light;
  logic [11:0] count;
  logic        phase_done;

  always #5 clk = ~clk;

  lane_phase_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .tick        (tick),
    .green_time  (green_time),
    .green_valid (green_valid),
    .req         (req),
    .dur_en      (dur_en),
    .lane_sel    (lane_sel),
    .light       (light),
    .count       (count),
    .phase_done  (phase_done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Model: stage -1 idle, 0 waiting for a duration, 1..3 the timed phases of one lane.
  int m_stage, m_lane, m_cnt;
  bit m_req, m_den, m_pd;
  int lamp_of[4] = '{0, 1, 2, 0};
  int dur_after[4] = '{0, YT, AT, 0};

  function automatic int m_light();
    return (m_stage < 0) ? 3 : lamp_of[m_stage];
  endfunction

  task model_step(input bit r, input bit rn, input bit tk, input bit gv, input int gt);
    if (r) begin
      m_stage = -1; m_lane = 0; m_cnt = 0; m_req = 0; m_den = 0; m_pd = 0;
    end else begin
      m_den = 0;
      m_pd  = 0;
      if (m_stage < 0) begin
        if (rn) begin m_stage = 0; m_req = 1; end
      end else if (m_stage == 0) begin
        if (gv && rn) begin
          m_cnt = (gt < MING) ? MING : ((gt > MAXG) ? MAXG : gt);
          m_den = 1; m_req = 0; m_stage = 1;
        end
      end else if (m_cnt == 0) begin
        m_stage = 3; m_cnt = AT;
      end else if (rn && tk) begin
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else if (m_stage == 3) begin
          m_lane = (m_lane + 1) % 4; m_pd = 1; m_req = 1; m_stage = 0; m_cnt = 0;
        end else begin
          m_cnt = dur_after[m_stage]; m_stage = m_stage + 1;
        end
      end
    end
  endtask

  task automatic cyc(input bit r, input bit rn, input bit tk, input bit gv, input logic [11:0] gt);
    rst = r; run = rn; tick = tk; green_valid = gv; green_time = gt;
    @(posedge clk);
    model_step(r, rn, tk, gv, int'(gt));
    #1;
    check("cycle", 32'({light, lane_sel, count, req, dur_en, phase_done}),
          32'({2'(m_light()), 2'(m_lane), 12'(m_cnt), m_req, m_den, m_pd}));
  endtask

  int pd_total;

  // Accept one green duration and tick every cycle until the lane advances.
  task automatic accept_and_run(input logic [11:0] gt, output int g, output int y,
                                output int a, output int dens);
    bit done;
    g = 0; y = 0; a = 0; dens = 0; done = 0;
    cyc(0, 1, 0, 1, gt);
    for (int i = 0; i < 400 && !done; i++) begin
      if (dur_en) dens++;
      if (phase_done) begin
        done = 1;
        pd_total++;
      end else if (light == 2'b01) g++;
      else if (light == 2'b10) y++;
      else if (light == 2'b00) a++;
      if (!done) cyc(0, 1, 1, 0, 12'd0);
    end
    check("pd_timeout", 32'(done), 32'd1);
  endtask

  int g, y, a, dens, n;
  bit hit;

  initial begin
    pd_total = 0;
    // reset state
    cyc(1, 0, 0, 0, 12'd0);
    cyc(1, 1, 1, 1, 12'd9);
    check("rst_light", 32'(light), 32'd3);
    check("rst_state", 32'({lane_sel, count, req, dur_en, phase_done}), 32'd0);

    // 1: request one cycle after leaving IDLE, nominal 10-tick green
    cyc(0, 1, 0, 0, 12'd0);
    check("t1_req", 32'(req), 32'd1);
    accept_and_run(12'd10, g, y, a, dens);
    check("t1_green", 32'(g), 32'd10);
    check("t1_yellow", 32'(y), 32'd3);
    check("t1_allred", 32'(a), 32'd2);
    check("t1_dur_en", 32'(dens), 32'd1);
    check("t1_lane", 32'(lane_sel), 32'd1);
    check("t1_req_again", 32'(req), 32'd1);

    // 4: freeze mid-green with count 7
    cyc(0, 1, 0, 1, 12'd20);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      cyc(0, 1, 1, 0, 12'd0);
      if (count == 12'd7) hit = 1;
    end
    check("t4_reach7", 32'(hit), 32'd1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 12'd9);
    check("t4_frozen", 32'({light, count}), 32'({2'b01, 12'd7}));
    n = 0; hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc(0, 1, 1, 0, 12'd0);
      n++;
      if (light == 2'b10) hit = 1;
    end
    check("t4_resume_ticks", 32'(n), 32'd7);

    // 5: reset in YELLOW with count 2
    cyc(0, 1, 1, 0, 12'd0);
    check("t5_yellow2", 32'({light, count}), 32'({2'b10, 12'd2}));
    cyc(1, 1, 1, 1, 12'd5);
    check("t5_rst", 32'({light, lane_sel, count, req}), 32'({2'b11, 2'b00, 12'd0, 1'b0}));

    // 2/3: clamp limits and a full wrap of lanes
    cyc(0, 1, 0, 0, 12'd0);
    pd_total = 0;
    accept_and_run(12'd0, g, y, a, dens);
    check("t2_min", 32'(g), 32'd5);
    check("t3_lane1", 32'(lane_sel), 32'd1);
    accept_and_run(12'hFFF, g, y, a, dens);
    check("t2_max", 32'(g), 32'd120);
    check("t3_lane2", 32'(lane_sel), 32'd2);
    accept_and_run(12'd7, g, y, a, dens);
    check("t3_lane3", 32'(lane_sel), 32'd3);
    accept_and_run(12'd121, g, y, a, dens);
    check("t2_above_max", 32'(g), 32'd120);
    check("t3_wrap", 32'(lane_sel), 32'd0);
    check("t3_pd_count", 32'(pd_total), 32'd4);

    // 6: tick coincident with green_valid in REQ is dropped
    cyc(0, 1, 1, 1, 12'd8);
    check("t6_count", 32'({light, count}), 32'({2'b01, 12'd8}));
    cyc(0, 1, 1, 0, 12'd0);
    check("t6_next", 32'(count), 32'd7);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [11:0] gt;
      gt = ($urandom % 4 == 0) ? 12'($urandom) : 12'($urandom % 16);
      cyc(($urandom % 400) == 0, ($urandom % 10) != 0, ($urandom % 3) == 0,
          ($urandom % 4) == 0, gt);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
